// File: rtl/synth_pkg.sv
// Shared definitions for the synth datapath: wavetable geometry defaults,
// the RAM4K depth and the wavetable_reader FSM state encoding.
package synth_pkg;

   localparam int DEF_ADDR_W  = 12;
   localparam int DEF_DATA_W  = 20;
   localparam int DEF_FRAC_W  = 12;
   localparam int RAM4K_DEPTH = 1 << DEF_ADDR_W;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT0 = 2'd1;
   localparam logic [1:0] ST_WAIT1 = 2'd2;
   localparam logic [1:0] ST_CALC  = 2'd3;

endpackage

// File: rtl/phase_accumulator.sv
// Phase register for the wavetable oscillator. Clear wins over step; the
// sum wraps naturally modulo 2**PHASE_W.
module phase_accumulator #(
   parameter int PHASE_W = 24
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               step,
   input  logic [PHASE_W-1:0] inc,
   output logic [PHASE_W-1:0] phase
);

   // Advance the phase by one step per accepted sample, or return it to zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase <= '0;
      end else if (clr) begin
         phase <= '0;
      end else if (step) begin
         phase <= phase + inc;
      end
   end

endmodule

// File: rtl/wavetable_reader.sv
// Read-side engine for the RAM4K wavetable. One signed sample is produced per
// accepted sample_req strobe. Optional macro WAVETABLE_INTERP_EN enables
// linear interpolation between adjacent table entries; without it the phase
// fraction is simply truncated.
module wavetable_reader
   import synth_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int FRAC_W = DEF_FRAC_W,
   parameter int RD_LAT = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic [ADDR_W+FRAC_W-1:0]  phase_inc,
   input  logic                      sample_req,
   output logic                      ram_load,
   output logic [ADDR_W-1:0]         ram_sel,
   input  logic [DATA_W-1:0]         ram_out,
   output logic [DATA_W-1:0]         sample_out,
   output logic                      sample_valid,
   output logic                      busy,
   output logic                      overrun
);

   localparam int PHASE_W = ADDR_W + FRAC_W;

   logic [1:0]         state;
   logic [3:0]         wait_cnt;
   logic [PHASE_W-1:0] phase;
   logic               accept;
   logic               capture;
   logic               clr_phase;

   assign ram_load  = 1'b0;
   assign busy      = (state != ST_IDLE);
   assign accept    = enable && sample_req && (state == ST_IDLE);
   assign capture   = (wait_cnt == 4'(RD_LAT));
   assign clr_phase = !enable;

   phase_accumulator #(
      .PHASE_W (PHASE_W)
   ) u_phase (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_phase),
      .step  (accept),
      .inc   (phase_inc),
      .phase (phase)
   );

`ifdef WAVETABLE_INTERP_EN
   logic [FRAC_W-1:0]               frac;
   logic signed [DATA_W-1:0]        s0;
   logic signed [DATA_W-1:0]        s1;
   logic signed [DATA_W:0]          diff;
   logic signed [DATA_W+FRAC_W+1:0] prod;
   logic signed [DATA_W-1:0]        interp;

   // Blend the two neighbouring entries by the latched fraction; the product is left unsaturated.
   always_comb begin
      diff   = {s1[DATA_W-1], s1} - {s0[DATA_W-1], s0};
      prod   = diff * $signed({1'b0, frac});
      interp = s0 + DATA_W'(prod >>> FRAC_W);
   end
`else
   logic unused_frac;
   assign unused_frac = ^phase[FRAC_W-1:0];
`endif

   // Request/wait/capture sequencer; enable low aborts any read in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         wait_cnt     <= '0;
         ram_sel      <= '0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
`ifdef WAVETABLE_INTERP_EN
         frac         <= '0;
         s0           <= '0;
         s1           <= '0;
`endif
      end else begin
         sample_valid <= 1'b0;
         if (enable && sample_req && (state != ST_IDLE)) begin
            overrun <= 1'b1;
         end
         if (!enable) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (sample_req) begin
                     ram_sel  <= phase[PHASE_W-1:FRAC_W];
`ifdef WAVETABLE_INTERP_EN
                     frac     <= phase[FRAC_W-1:0];
`endif
                     wait_cnt <= '0;
                     state    <= ST_WAIT0;
                  end
               end
               ST_WAIT0: begin
                  if (capture) begin
`ifdef WAVETABLE_INTERP_EN
                     s0       <= ram_out;
                     ram_sel  <= ram_sel + ADDR_W'(1);
                     wait_cnt <= '0;
                     state    <= ST_WAIT1;
`else
                     sample_out   <= ram_out;
                     sample_valid <= 1'b1;
                     state        <= ST_IDLE;
`endif
                  end else begin
                     wait_cnt <= wait_cnt + 4'd1;
                  end
               end
`ifdef WAVETABLE_INTERP_EN
               ST_WAIT1: begin
                  if (capture) begin
                     s1    <= ram_out;
                     state <= ST_CALC;
                  end else begin
                     wait_cnt <= wait_cnt + 4'd1;
                  end
               end
               ST_CALC: begin
                  sample_out   <= interp;
                  sample_valid <= 1'b1;
                  state        <= ST_IDLE;
               end
`endif
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wavetable_reader.sv
// Self-checking bench for wavetable_reader with a registered RAM4K model
// (RD_LAT=1). Expectations follow WAVETABLE_INTERP_EN when it is defined.
module tb_wavetable_reader;
   import synth_pkg::*;

   localparam int ADDR_W  = 12;
   localparam int DATA_W  = 20;
   localparam int PHASE_W = 24;
`ifdef WAVETABLE_INTERP_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 2;
`endif

   typedef struct {
      bit          restart;
      int          scale;
      logic [23:0] inc;
      logic [19:0] exp_plain;
      logic [19:0] exp_interp;
   } vec_t;

   logic                clk;
   logic                rst_n;
   logic                enable;
   logic [PHASE_W-1:0]  phase_inc;
   logic                sample_req;
   logic                ram_load;
   logic [ADDR_W-1:0]   ram_sel;
   logic [DATA_W-1:0]   ram_out;
   logic [DATA_W-1:0]   sample_out;
   logic                sample_valid;
   logic                busy;
   logic                overrun;

   logic [DATA_W-1:0]   mem [0:RAM4K_DEPTH-1];
   int                  checks;
   int                  errors;
   vec_t                vecs [8];

   wavetable_reader #(
      .RD_LAT (1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .phase_inc    (phase_inc),
      .sample_req   (sample_req),
      .ram_load     (ram_load),
      .ram_sel      (ram_sel),
      .ram_out      (ram_out),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   // Free-running system clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM4K model with a registered OUT port.
   always @(posedge clk) ram_out <= mem[ram_sel];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic fill_mem(input int scale, input int offset);
      for (int i = 0; i < RAM4K_DEPTH; i++) mem[i] = DATA_W'(i * scale + offset);
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      enable     = 1'b0;
      sample_req = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_valid(output int lat);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (sample_valid === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic apply_stimulus(input string name, input logic [19:0] expected);
      int lat;
      sample_req = 1'b1;
      tick();
      sample_req = 1'b0;
      wait_valid(lat);
      check_output({name, "_latency"}, 32'(lat), 32'(LAT));
      check_output({name, "_sample"}, 32'(sample_out), 32'(expected));
      check_output({name, "_ram_load"}, 32'(ram_load), 32'd0);
   endtask

   initial begin
      int lat;
      int bad;
      int nvalid;
      logic [19:0] exp_v;

      checks     = 0;
      errors     = 0;
      rst_n      = 1'b0;
      enable     = 1'b0;
      sample_req = 1'b0;
      phase_inc  = '0;

      vecs[0] = '{1'b1, 1,  24'h001000, 20'd0,  20'd0};
      vecs[1] = '{1'b0, 1,  24'h001000, 20'd1,  20'd1};
      vecs[2] = '{1'b0, 1,  24'h001000, 20'd2,  20'd2};
      vecs[3] = '{1'b0, 1,  24'h001000, 20'd3,  20'd3};
      vecs[4] = '{1'b1, 16, 24'h000800, 20'd0,  20'd0};
      vecs[5] = '{1'b0, 16, 24'h000800, 20'd0,  20'd8};
      vecs[6] = '{1'b0, 16, 24'h000800, 20'd16, 20'd16};
      vecs[7] = '{1'b0, 16, 24'h000800, 20'd16, 20'd24};

      // Reset state
      fill_mem(1, 0);
      do_reset();
      check_output("rst_sample_out", 32'(sample_out), 32'd0);
      check_output("rst_ram_sel", 32'(ram_sel), 32'd0);
      check_output("rst_valid", 32'(sample_valid), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_overrun", 32'(overrun), 32'd0);
      check_output("rst_ram_load", 32'(ram_load), 32'd0);

      // Table-driven sequences: identity table, then half-step on a x16 table
      for (int v = 0; v < 8; v++) begin
         if (vecs[v].restart) begin
            fill_mem(vecs[v].scale, 0);
            do_reset();
            enable = 1'b1;
         end
         phase_inc = vecs[v].inc;
`ifdef WAVETABLE_INTERP_EN
         exp_v = vecs[v].exp_interp;
`else
         exp_v = vecs[v].exp_plain;
`endif
         apply_stimulus($sformatf("vec%0d", v), exp_v);
         repeat (5) tick();
      end

      // Phase wrap: walk the whole table, then 4095 followed by 0
      fill_mem(1, 0);
      do_reset();
      enable    = 1'b1;
      phase_inc = 24'h001000;
      bad = 0;
      for (int i = 0; i < 4095; i++) begin
         sample_req = 1'b1;
         tick();
         sample_req = 1'b0;
         wait_valid(lat);
         if (lat != LAT || sample_out !== DATA_W'(i)) bad++;
      end
      check_output("preload_errors", 32'(bad), 32'd0);
      apply_stimulus("wrap_4095", 20'd4095);
      check_output("wrap_sel_known_a", 32'($isunknown(ram_sel)), 32'd0);
      apply_stimulus("wrap_0", 20'd0);
      check_output("wrap_sel_known_b", 32'($isunknown(ram_sel)), 32'd0);

      // Request while busy: one sample, sticky overrun until reset
      fill_mem(1, 7);
      do_reset();
      enable     = 1'b1;
      phase_inc  = 24'h001000;
      sample_req = 1'b1;
      tick();
      tick();
      sample_req = 1'b0;
      nvalid = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (sample_valid === 1'b1) nvalid++;
      end
      check_output("ovr_valid_count", 32'(nvalid), 32'd1);
      check_output("ovr_sample", 32'(sample_out), 32'd7);
      check_output("ovr_flag", 32'(overrun), 32'd1);
      repeat (5) tick();
      check_output("ovr_sticky", 32'(overrun), 32'd1);
      rst_n = 1'b0;
      tick();
      check_output("ovr_cleared", 32'(overrun), 32'd0);
      rst_n = 1'b1;

      // Enable dropped during WAIT0
      fill_mem(1, 7);
      do_reset();
      enable    = 1'b1;
      phase_inc = 24'h001000;
      apply_stimulus("abort_pre0", 20'd7);
      apply_stimulus("abort_pre1", 20'd8);
      sample_req = 1'b1;
      tick();
      sample_req = 1'b0;
      check_output("abort_busy_in", 32'(busy), 32'd1);
      enable = 1'b0;
      tick();
      check_output("abort_busy_out", 32'(busy), 32'd0);
      nvalid = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (sample_valid === 1'b1) nvalid++;
      end
      check_output("abort_no_valid", 32'(nvalid), 32'd0);
      check_output("abort_hold", 32'(sample_out), 32'd8);
      enable = 1'b1;
      tick();
      apply_stimulus("abort_after", 20'd7);

      // Reset pulse during WAIT0
      fill_mem(1, 7);
      do_reset();
      enable    = 1'b1;
      phase_inc = 24'h001000;
      apply_stimulus("midrst_pre", 20'd7);
      sample_req = 1'b1;
      tick();
      sample_req = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_output("midrst_sample_out", 32'(sample_out), 32'd0);
      check_output("midrst_ram_sel", 32'(ram_sel), 32'd0);
      check_output("midrst_valid", 32'(sample_valid), 32'd0);
      check_output("midrst_busy", 32'(busy), 32'd0);
      check_output("midrst_overrun", 32'(overrun), 32'd0);
      nvalid = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (sample_valid === 1'b1) nvalid++;
      end
      check_output("midrst_no_valid", 32'(nvalid), 32'd0);
      apply_stimulus("midrst_after", 20'd7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
